// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature encoder counter.
//   S00/S10/S11/S01 : Gray phase states, written as {A,B}
//   qdec_mv_e       : decoder classification of one sampled phase transition
//   SEG_HEX/seg_hex : hex digit to seven-segment pattern (bit0 = a ... bit6 = g, active-high)
package qdec_pkg;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S01 = 2'b01;

   typedef enum logic [1:0] {
      MV_NONE,
      MV_UP,
      MV_DN,
      MV_BAD
   } qdec_mv_e;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
      return SEG_HEX[nibble];
   endfunction

endpackage

// File: rtl/qdec_debounce.sv
// Two-flop synchroniser followed by a level debouncer for one encoder phase.
//   clkin : system clock
//   rst   : asynchronous active-low reset
//   pin_i : raw, asynchronous, bouncy phase input
//   lvl_o : debounced level; changes DEB_CYCLES+2 cycles after a clean pin edge
module qdec_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clkin,
   input  logic rst,
   input  logic pin_i,
   output logic lvl_o
);

   logic       s1_q;
   logic       s2_q;
   logic       lvl_q;
   logic [7:0] deb_q;

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         lvl_q <= 1'b0;
         deb_q <= '0;
      end else begin
         s1_q <= pin_i;
         s2_q <= s1_q;
         if (s2_q == lvl_q) begin
            deb_q <= '0;
         end else if (deb_q == 8'(DEB_CYCLES - 1)) begin
            // DEB_CYCLES consecutive differing samples: accept the new level
            lvl_q <= s2_q;
            deb_q <= '0;
         end else begin
            deb_q <= deb_q + 8'd1;
         end
      end
   end

   assign lvl_o = lvl_q;

endmodule

// File: rtl/quad_enc_counter.sv
// Quadrature encoder front end: debounce, x1/x4 direction decode, up/down
// counter with wrap or saturate, and a scanned hex seven-segment display.
// Optional macro QUAD_ENC_ERR_DET_EN builds the sticky illegal-transition flag;
// without it err is tied low.
//   clkin   : system clock
//   rst     : asynchronous active-low reset
//   Ain/Bin : raw encoder phases
//   A/B     : debounced phases
//   cnt     : counter value
//   dir     : last counted direction (1 = up)
//   step    : one-cycle pulse per count attempt
//   codeout : segments of the active digit, active-high
//   dig_sel : active-low one-hot digit enables
//   err     : sticky illegal-transition flag
//
// Phase state {A,B} | meaning
//   S00             | both low
//   S10             | A high, B low (first up step from S00)
//   S11             | both high
//   S01             | B high, A low (first down step from S00)
module quad_enc_counter
   import qdec_pkg::*;
#(
   parameter  int CNT_W      = 4,
   parameter  int DEB_CYCLES = 16,
   parameter  int MODE_X4    = 0,
   parameter  int WRAP       = 1,
   parameter  int SCAN_DIV   = 4,
   localparam int NDIG       = (CNT_W + 3) / 4
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             Ain,
   input  logic             Bin,
   output logic             A,
   output logic             B,
   output logic [CNT_W-1:0] cnt,
   output logic             dir,
   output logic             step,
   output logic [6:0]       codeout,
   output logic [NDIG-1:0]  dig_sel,
   output logic             err
);

   localparam int SET_W = $clog2(DEB_CYCLES + 4);
   localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW    = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic             a_w, b_w;
   logic [1:0]       ab;
   logic [1:0]       prev_q;
   logic [SET_W-1:0] settle_q;
   logic             settled;
   qdec_mv_e         mv;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, step_q;
   logic [SW-1:0]    scan_q;
   logic [DW-1:0]    dig_q;
   logic [6:0]       codeout_q;
   logic [NDIG-1:0]  dig_sel_q;
   logic [4*NDIG-1:0] cnt_ext;
   logic [3:0]       nib;

   qdec_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clkin (clkin),
      .rst   (rst),
      .pin_i (Ain),
      .lvl_o (a_w)
   );

   qdec_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clkin (clkin),
      .rst   (rst),
      .pin_i (Bin),
      .lvl_o (b_w)
   );

   assign ab      = {a_w, b_w};
   // Settle window covers the debounce latency so pins already high at reset
   // are absorbed into prev_q instead of being decoded as a transition.
   assign settled = (settle_q == '0);

   always_comb begin
      mv = MV_NONE;
      if (ab != prev_q) begin
         if ((ab ^ prev_q) == 2'b11) begin
            mv = MV_BAD;
         end else if (MODE_X4 != 0) begin
            unique case (prev_q)
               S00:     mv = (ab == S10) ? MV_UP : MV_DN;
               S10:     mv = (ab == S11) ? MV_UP : MV_DN;
               S11:     mv = (ab == S01) ? MV_UP : MV_DN;
               default: mv = (ab == S00) ? MV_UP : MV_DN;
            endcase
         end else if (!prev_q[1] && ab[1]) begin
            mv = ab[0] ? MV_DN : MV_UP;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (mv == MV_UP) begin
         if ((WRAP != 0) || (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      end else if (mv == MV_DN) begin
         if ((WRAP != 0) || (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         prev_q   <= S00;
         settle_q <= SET_W'(DEB_CYCLES + 3);
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         prev_q <= ab;
         step_q <= 1'b0;
         if (!settled) begin
            settle_q <= settle_q - 1'b1;
         end else if ((mv == MV_UP) || (mv == MV_DN)) begin
            step_q <= 1'b1;
            dir_q  <= (mv == MV_UP);
            cnt_q  <= cnt_d;
         end
      end
   end

`ifdef QUAD_ENC_ERR_DET_EN
   logic err_q;

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (settled && (mv == MV_BAD)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      cnt_ext = '0;
      cnt_ext[CNT_W-1:0] = cnt_q;
      nib = 4'h0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig_q == DW'(i)) nib = cnt_ext[4*i +: 4];
      end
   end

   always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
         scan_q    <= SW'(SCAN_DIV - 1);
         dig_q     <= '0;
         codeout_q <= 7'h3F;
         dig_sel_q <= ~NDIG'(1);
      end else begin
         codeout_q <= seg_hex(nib);
         dig_sel_q <= ~(NDIG'(1) << dig_q);
         if (scan_q == '0) begin
            scan_q <= SW'(SCAN_DIV - 1);
            dig_q  <= (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + 1'b1;
         end else begin
            scan_q <= scan_q - 1'b1;
         end
      end
   end

   assign A       = a_w;
   assign B       = b_w;
   assign cnt     = cnt_q;
   assign dir     = dir_q;
   assign step    = step_q;
   assign codeout = codeout_q;
   assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_quad_enc_counter.sv
module tb_quad_enc_counter;

   logic clkin = 1'b0;
   always #5 clkin = ~clkin;

   logic rst, Ain, Bin;
   logic [3:0] a_o, b_o, dir_o, step_o, err_o;
   logic [3:0] cnt0, cnt1, cnt2;
   logic [7:0] cnt3;
   logic [6:0] code0, code1, code2, code3;
   logic       ds0, ds1, ds2;
   logic [1:0] ds3;

   // instance 0: x4 wrap, 1: x1 wrap, 2: x1 saturate, 3: 8-bit x4 saturate (2 digits)
   localparam int CW [4] = '{4, 4, 4, 8};
   localparam int X4 [4] = '{1, 0, 0, 1};
   localparam int WR [4] = '{1, 1, 0, 0};

`ifdef QUAD_ENC_ERR_DET_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   quad_enc_counter #(.CNT_W(4), .DEB_CYCLES(16), .MODE_X4(1), .WRAP(1), .SCAN_DIV(4)) u_d0 (
      .clkin(clkin), .rst(rst), .Ain(Ain), .Bin(Bin), .A(a_o[0]), .B(b_o[0]), .cnt(cnt0),
      .dir(dir_o[0]), .step(step_o[0]), .codeout(code0), .dig_sel(ds0), .err(err_o[0]));
   quad_enc_counter #(.CNT_W(4), .DEB_CYCLES(16), .MODE_X4(0), .WRAP(1), .SCAN_DIV(4)) u_d1 (
      .clkin(clkin), .rst(rst), .Ain(Ain), .Bin(Bin), .A(a_o[1]), .B(b_o[1]), .cnt(cnt1),
      .dir(dir_o[1]), .step(step_o[1]), .codeout(code1), .dig_sel(ds1), .err(err_o[1]));
   quad_enc_counter #(.CNT_W(4), .DEB_CYCLES(16), .MODE_X4(0), .WRAP(0), .SCAN_DIV(4)) u_d2 (
      .clkin(clkin), .rst(rst), .Ain(Ain), .Bin(Bin), .A(a_o[2]), .B(b_o[2]), .cnt(cnt2),
      .dir(dir_o[2]), .step(step_o[2]), .codeout(code2), .dig_sel(ds2), .err(err_o[2]));
   quad_enc_counter #(.CNT_W(8), .DEB_CYCLES(16), .MODE_X4(1), .WRAP(0), .SCAN_DIV(4)) u_d3 (
      .clkin(clkin), .rst(rst), .Ain(Ain), .Bin(Bin), .A(a_o[3]), .B(b_o[3]), .cnt(cnt3),
      .dir(dir_o[3]), .step(step_o[3]), .codeout(code3), .dig_sel(ds3), .err(err_o[3]));

   logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int tests = 0;
   int fails = 0;
   int p;                 // position in the up Gray cycle: 0=00 1=10 2=11 3=01
   int exp_cnt [4];
   bit exp_dir [4];
   int exp_steps [4];
   int steps_seen [4];
   bit exp_err;

   always @(negedge clkin)
      for (int i = 0; i < 4; i++)
         if (step_o[i] === 1'b1) steps_seen[i]++;

   function automatic bit ga(int q); return (q == 1) || (q == 2); endfunction
   function automatic bit gb(int q); return (q == 2) || (q == 3); endfunction

   function automatic logic [31:0] cnt_of(int i);
      case (i)
         0: return 32'(cnt0);
         1: return 32'(cnt1);
         2: return 32'(cnt2);
         default: return 32'(cnt3);
      endcase
   endfunction

   function automatic logic [6:0] code_of(int i);
      case (i)
         0: return code0;
         1: return code1;
         default: return code2;
      endcase
   endfunction

   function automatic logic ds_of(int i);
      case (i)
         0: return ds0;
         1: return ds1;
         default: return ds2;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic count_model(int i, int d);
      int mx;
      mx = (1 << CW[i]) - 1;
      exp_steps[i]++;
      exp_dir[i] = (d > 0);
      if (WR[i] != 0) exp_cnt[i] = (exp_cnt[i] + d) & mx;
      else if (exp_cnt[i] + d < 0) exp_cnt[i] = 0;
      else if (exp_cnt[i] + d > mx) exp_cnt[i] = mx;
      else exp_cnt[i] = exp_cnt[i] + d;
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s A%0d", tag, i), 32'(a_o[i]), 32'(ga(p)));
         chk($sformatf("%s B%0d", tag, i), 32'(b_o[i]), 32'(gb(p)));
         chk($sformatf("%s cnt%0d", tag, i), cnt_of(i), 32'(exp_cnt[i]));
         chk($sformatf("%s dir%0d", tag, i), 32'(dir_o[i]), 32'(exp_dir[i]));
         chk($sformatf("%s steps%0d", tag, i), 32'(steps_seen[i]), 32'(exp_steps[i]));
         chk($sformatf("%s err%0d", tag, i), 32'(err_o[i]), 32'(exp_err));
      end
   endtask

   task automatic drive(int np);
      @(negedge clkin);
      Ain = ga(np);
      Bin = gb(np);
      p = np;
      repeat (40) @(negedge clkin);
   endtask

   task automatic move(int d, string tag);
      int np;
      np = (p + d + 4) % 4;
      for (int i = 0; i < 4; i++) begin
         if (X4[i] != 0) count_model(i, d);
         else if (d == 1 && p == 0) count_model(i, 1);
         else if (d == -1 && p == 3) count_model(i, -1);
      end
      drive(np);
      check_all(tag);
   endtask

   task automatic bad_move(string tag);
      if (ERR_EN) exp_err = 1'b1;
      drive((p + 2) % 4);
      check_all(tag);
   endtask

   task automatic glitch(bit on_a, int w, string tag);
      @(negedge clkin);
      if (on_a) Ain = ~ga(p); else Bin = ~gb(p);
      repeat (w) @(negedge clkin);
      Ain = ga(p);
      Bin = gb(p);
      repeat (40) @(negedge clkin);
      check_all(tag);
   endtask

   task automatic do_reset(int np, string tag);
      @(negedge clkin);
      rst = 1'b0;
      Ain = ga(np);
      Bin = gb(np);
      p = np;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_cnt[i] = 0;
         exp_dir[i] = 1'b0;
         chk($sformatf("%s rA%0d", tag, i), 32'(a_o[i]), 32'd0);
         chk($sformatf("%s rB%0d", tag, i), 32'(b_o[i]), 32'd0);
         chk($sformatf("%s rcnt%0d", tag, i), cnt_of(i), 32'd0);
         chk($sformatf("%s rdir%0d", tag, i), 32'(dir_o[i]), 32'd0);
         chk($sformatf("%s rstep%0d", tag, i), 32'(step_o[i]), 32'd0);
         chk($sformatf("%s rerr%0d", tag, i), 32'(err_o[i]), 32'd0);
      end
      exp_err = 1'b0;
      chk({tag, " rcode0"}, 32'(code0), 32'h3F);
      chk({tag, " rcode3"}, 32'(code3), 32'h3F);
      chk({tag, " rds0"}, 32'(ds0), 32'd0);
      chk({tag, " rds3"}, 32'(ds3), 32'h2);
      @(negedge clkin);
      rst = 1'b1;
      repeat (100) @(negedge clkin);
      check_all({tag, " post"});
   endtask

   task automatic chk_disp(string tag);
      int changes;
      logic [1:0] prev_ds;
      logic [3:0] nib;
      changes = 0;
      prev_ds = ds3;
      for (int k = 0; k < 17; k++) begin
         @(negedge clkin);
         if (k > 0 && ds3 != prev_ds) changes++;
         prev_ds = ds3;
         nib = (ds3 == 2'b01) ? 4'(exp_cnt[3] >> 4) : 4'(exp_cnt[3]);
         chk({tag, " ds3 onehot"}, 32'((ds3 == 2'b01) || (ds3 == 2'b10)), 32'd1);
         chk({tag, " code3"}, 32'(code3), 32'(lut[nib]));
      end
      chk({tag, " scan changes"}, 32'(changes), 32'd4);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s code%0d", tag, i), 32'(code_of(i)), 32'(lut[4'(exp_cnt[i])]));
         chk($sformatf("%s ds%0d", tag, i), 32'(ds_of(i)), 32'd0);
      end
   endtask

   initial begin
      int r;
      rst = 1'b0;
      Ain = 1'b0;
      Bin = 1'b0;
      p = 0;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_cnt[i] = 0;
         exp_dir[i] = 1'b0;
         exp_steps[i] = 0;
      end

      do_reset(0, "init");
      chk_disp("disp0");

      for (int g = 0; g < 10; g++) begin
         @(negedge clkin);
         Ain = 1'b1;
         @(negedge clkin);
         Ain = 1'b0;
         repeat (10) @(negedge clkin);
      end
      check_all("glitch1");
      glitch(1'b1, 15, "glitch15");

      for (int s = 0; s < 4; s++) move(1, "up1");
      chk("x4 cnt after one cycle", 32'(cnt0), 32'd4);
      chk("x4 steps after one cycle", 32'(steps_seen[0]), 32'd4);

      for (int s = 0; s < 64; s++) move(1, "up17");
      chk("x1 cnt after 17 cycles", 32'(cnt1), 32'd1);
      for (int s = 0; s < 8; s++) move(-1, "dn2");
      chk("x1 wrap down", 32'(cnt1), 32'hF);
      chk("x1 dir down", 32'(dir_o[1]), 32'd0);

      do_reset(p, "rst2");
      for (int s = 0; s < 12; s++) move(-1, "satdn");
      chk("sat low", 32'(cnt2), 32'd0);
      for (int s = 0; s < 80; s++) move(1, "satup");
      chk("sat high", 32'(cnt2), 32'hF);
      chk_disp("disp1");

      for (int s = 0; s < 60; s++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4) move(1, "rnd up");
         else if (r < 8) move(-1, "rnd dn");
         else if (r == 8) glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 15)), "rnd glitch");
         else bad_move("rnd bad");
         if (s % 15 == 14) chk_disp("rnd disp");
      end

      bad_move("bad");
      move(1, "sticky1");
      move(1, "sticky2");

      do_reset(0, "rst3");
      for (int s = 0; s < 58; s++) move(1, "to3A");
      chk("cnt3 3A", 32'(cnt3), 32'h3A);
      chk_disp("disp3A");

      do_reset(2, "pins high");
      chk("pins high err", 32'(err_o[0]), 32'd0);
      chk("pins high cnt", 32'(cnt0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
